// File: rtl/bd_tag_pkg.sv
// Shared definitions for the BD tag splitter/merger pair: field widths, the
// tag-input leaf code and the packed routed-tag word.
package bd_tag_pkg;

    localparam int NBDPAYLOAD  = 34;
    localparam int NLEAF       = 5;
    localparam int NGLOBAL     = 8;
    localparam int NTAG        = 11;
    localparam int NCT         = 9;
    localparam int TAG_IN_CODE = 7;
    localparam int NCNT        = 16;

    typedef struct packed {
        logic [NGLOBAL-1:0] global_tag;
        logic [NTAG-1:0]    tag;
        logic [NCT-1:0]     ct;
    } tag_word_t;

    typedef enum logic [0:0] {
        GRANT_LOCAL  = 1'b0,
        GRANT_GLOBAL = 1'b1
    } grant_e;

endpackage : bd_tag_pkg

// File: rtl/bd_tag_fifo2.sv
// Two-entry valid/ack FIFO with registered head; accepts a push while holding
// one entry even if that entry pops in the same cycle.
module bd_tag_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         in_v,
    input  logic [W-1:0] in_data,
    output logic         in_a,
    output logic         out_v,
    output logic [W-1:0] out_data,
    input  logic         out_a
);

    logic [W-1:0] head_r, tail_r, head_n_s, tail_n_s;
    logic [1:0]   count_r, count_n_s;
    logic         valid_r;
    logic         push_s, pop_s;

    assign in_a     = (count_r != 2'd2);
    assign out_v    = valid_r;
    assign out_data = head_r;
    assign push_s   = in_v & in_a;
    assign pop_s    = valid_r & out_a;

    // Next head/tail/occupancy; the head always holds the oldest entry.
    always_comb begin
        head_n_s  = head_r;
        tail_n_s  = tail_r;
        count_n_s = count_r;
        case (count_r)
            2'd0: begin
                if (push_s) begin
                    head_n_s  = in_data;
                    count_n_s = 2'd1;
                end else begin
                    count_n_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_n_s = in_data;
                end else if (push_s) begin
                    tail_n_s  = in_data;
                    count_n_s = 2'd2;
                end else if (pop_s) begin
                    count_n_s = 2'd0;
                end else begin
                    count_n_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_n_s  = tail_r;
                    count_n_s = 2'd1;
                end else begin
                    count_n_s = 2'd2;
                end
            end
            default: begin
                count_n_s = 2'd0;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else if (srst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            count_r <= count_n_s;
            valid_r <= (count_n_s != 2'd0);
        end
    end

endmodule : bd_tag_fifo2

// File: rtl/bd_tag_merge.sv
// Merges local (host) tags and routed global tags into leaf-coded BD input
// words with round-robin arbitration, ct==0 discard and saturating statistics.
import bd_tag_pkg::*;

module bd_tag_merge #(
    parameter int NBDpayload  = NBDPAYLOAD,
    parameter int Nleaf       = NLEAF,
    parameter int Nglobal     = NGLOBAL,
    parameter int Ntag        = NTAG,
    parameter int Nct         = NCT,
    parameter int TAG_IN_code = TAG_IN_CODE,
    parameter int Ncnt        = NCNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tag_in_v,
    input  logic [Ntag-1:0]       tag_in_tag,
    input  logic [Nct-1:0]        tag_in_ct,
    output logic                  tag_in_a,
    input  logic                  gtag_in_v,
    input  logic [Nglobal-1:0]    gtag_in_global_tag,
    input  logic [Ntag-1:0]       gtag_in_tag,
    input  logic [Nct-1:0]        gtag_in_ct,
    output logic                  gtag_in_a,
    output logic                  BD_out_v,
    output logic [Nleaf-1:0]      BD_out_leaf_code,
    output logic [NBDpayload-1:0] BD_out_payload,
    input  logic                  BD_out_a,
    input  logic                  conf_en_local,
    input  logic                  conf_en_global,
    output logic [Ncnt-1:0]       stat_sent_local,
    output logic [Ncnt-1:0]       stat_sent_global,
    output logic [Ncnt-1:0]       stat_drop
);

    localparam int                 PADW   = NBDpayload - Ntag - Nct;
    localparam logic [Nleaf-1:0]   LEAF_C = Nleaf'(TAG_IN_code);

    grant_e                         last_grant_r;
    logic                           elig_l_s, elig_g_s, grant_l_s, grant_g_s;
    logic                           zero_l_s, zero_g_s, can_accept_s;
    logic                           push_v_s, unused_global_s;
    logic [NBDpayload-1:0]          push_payload_s;
    logic [Nleaf+NBDpayload-1:0]    fifo_out_s;
    logic [Ncnt-1:0]                sent_l_r, sent_g_r, drop_r;

    // The route field is consumed by the fabric; it never enters the BD word.
    assign unused_global_s = ^gtag_in_global_tag;

    assign elig_l_s  = tag_in_v & conf_en_local;
    assign elig_g_s  = gtag_in_v & conf_en_global;
    assign zero_l_s  = (tag_in_ct == '0);
    assign zero_g_s  = (gtag_in_ct == '0);

    // Round-robin grant: on a tie the source that did not win last goes first.
    always_comb begin
        grant_l_s = 1'b0;
        if (elig_l_s && (!elig_g_s || (last_grant_r == GRANT_GLOBAL))) begin
            grant_l_s = 1'b1;
        end else begin
            grant_l_s = 1'b0;
        end
        grant_g_s = elig_g_s & ~grant_l_s;
    end

    // Discards need no FIFO space, so a ct==0 tag is acked even when full.
    assign tag_in_a  = reset & grant_l_s & (can_accept_s | zero_l_s);
    assign gtag_in_a = reset & grant_g_s & (can_accept_s | zero_g_s);
    assign push_v_s  = (tag_in_a & ~zero_l_s) | (gtag_in_a & ~zero_g_s);
    assign push_payload_s = grant_l_s ? {{PADW{1'b0}}, tag_in_tag, tag_in_ct}
                                      : {{PADW{1'b0}}, gtag_in_tag, gtag_in_ct};

    bd_tag_fifo2 #(
        .W(Nleaf + NBDpayload)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .srst     (1'b0),
        .in_v     (push_v_s),
        .in_data  ({LEAF_C, push_payload_s}),
        .in_a     (can_accept_s),
        .out_v    (BD_out_v),
        .out_data (fifo_out_s),
        .out_a    (BD_out_a)
    );

    assign BD_out_leaf_code = fifo_out_s[Nleaf+NBDpayload-1:NBDpayload];
    assign BD_out_payload   = fifo_out_s[NBDpayload-1:0];

    // Arbitration history and saturating statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= GRANT_GLOBAL;
            sent_l_r     <= '0;
            sent_g_r     <= '0;
            drop_r       <= '0;
        end else begin
            if (tag_in_a) begin
                last_grant_r <= GRANT_LOCAL;
            end else if (gtag_in_a) begin
                last_grant_r <= GRANT_GLOBAL;
            end else begin
                last_grant_r <= last_grant_r;
            end
            if ((tag_in_a & ~zero_l_s) && (sent_l_r != '1)) begin
                sent_l_r <= sent_l_r + 1'b1;
            end
            if ((gtag_in_a & ~zero_g_s) && (sent_g_r != '1)) begin
                sent_g_r <= sent_g_r + 1'b1;
            end
            if (((tag_in_a & zero_l_s) | (gtag_in_a & zero_g_s)) && (drop_r != '1)) begin
                drop_r <= drop_r + 1'b1;
            end
        end
    end

    assign stat_sent_local  = sent_l_r;
    assign stat_sent_global = sent_g_r;
    assign stat_drop        = drop_r;

endmodule : bd_tag_merge
